// File: rtl/dac_output_stage.sv
// DAC output stage: round/shift, saturate and gain-ramp the signed FIR output into an
// offset-binary DAC code, with per-sample clip flag and saturating clip counter.
module dac_output_stage #(
   parameter int unsigned IN_WIDTH   = 44,
   parameter int unsigned DAC_WIDTH  = 14,
   parameter int unsigned BASE_SHIFT = 17,
   parameter int unsigned RAMP_STEP  = 1,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 aclr,
   input  logic                 ena,
   input  logic [IN_WIDTH-1:0]  fir_out,
   input  logic [3:0]           shift,
   input  logic                 mute,
   input  logic                 clip_clr,
   output logic [DAC_WIDTH-1:0] dac_in,
   output logic                 dac_valid,
   output logic                 clip,
   output logic [CNT_WIDTH-1:0] clip_count,
   output logic                 muted
);

   localparam int unsigned SW = 8;
   localparam int unsigned RW = IN_WIDTH + 1;
   localparam int unsigned PW = DAC_WIDTH + 10;
   localparam logic signed [RW-1:0] SAT_MAX = RW'(2 ** (DAC_WIDTH - 1) - 1);
   localparam logic signed [RW-1:0] SAT_MIN = -SAT_MAX - RW'(1);
   localparam logic [9:0] G_FULL = 10'd256;

   typedef enum logic [1:0] {StMuted, StRampUp, StUnmuted, StRampDown} ramp_st_e;

   logic [SW-1:0]               s_amt;
   logic signed [RW-1:0]        fir_ext, half, rnd;
   logic signed [RW-1:0]        r_d, r_q;
   logic signed [DAC_WIDTH-1:0] sat_d, sat_q;
   logic                        clip2_d, clip2_q;
   logic signed [PW-1:0]        prod;
   logic [DAC_WIDTH-1:0]        dac_d, dac_q;
   logic                        clip_q;
   logic [1:0]                  fill_d, fill_q;
   logic                        valid_d, valid_q;
   logic [CNT_WIDTH-1:0]        cnt_d, cnt_q;
   logic [8:0]                  g_d, g_q;
   logic [9:0]                  g_up;
   logic [8:0]                  g_dn;
   ramp_st_e                    st_d, st_q;
   logic                        unused_prod;

   // Stage 1: round-half-up and arithmetic shift at IN_WIDTH+1 bits
   always_comb begin
      s_amt = SW'(BASE_SHIFT) + SW'(shift);
      if (s_amt > SW'(IN_WIDTH - 1)) begin
         s_amt = SW'(IN_WIDTH - 1);
      end
      fir_ext = $signed({fir_out[IN_WIDTH-1], fir_out});
      half    = '0;
      if (s_amt != '0) begin
         half = RW'(1) << (s_amt - SW'(1));
      end
      rnd = fir_ext + half;
      r_d = rnd >>> s_amt;
   end

   // Stage 2: saturate to the signed DAC range
   always_comb begin
      clip2_d = 1'b1;
      sat_d   = r_q[DAC_WIDTH-1:0];
      if (r_q > SAT_MAX) begin
         sat_d = {1'b0, {(DAC_WIDTH - 1){1'b1}}};
      end else if (r_q < SAT_MIN) begin
         sat_d = {1'b1, {(DAC_WIDTH - 1){1'b0}}};
      end else begin
         clip2_d = 1'b0;
      end
   end

   // Stage 3: gain (floor of product / 256), then offset-binary via MSB inversion
   always_comb begin
      prod        = PW'(sat_q) * $signed({{(PW - 9){1'b0}}, g_q});
      dac_d       = {~prod[DAC_WIDTH+7], prod[DAC_WIDTH+6:8]};
      unused_prod = ^{prod[PW-1:DAC_WIDTH+8], prod[7:0]};
   end

   always_comb begin
      fill_d  = fill_q;
      valid_d = ena && (fill_q == 2'd3);
      cnt_d   = cnt_q;
      if (ena) begin
         if (fill_q != 2'd3) begin
            fill_d = fill_q + 2'd1;
         end
         if (clip_clr) begin
            cnt_d = CNT_WIDTH'(clip2_q);
         end else if (clip2_q && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   // Ramp FSM; the step applies on the same edge as the transition out of MUTED/UNMUTED
   always_comb begin
      g_up = {1'b0, g_q} + 10'(RAMP_STEP);
      if (g_up > G_FULL) begin
         g_up = G_FULL;
      end
      g_dn = (g_q > 9'(RAMP_STEP)) ? g_q - 9'(RAMP_STEP) : 9'd0;
      st_d = st_q;
      g_d  = g_q;
      if (ena) begin
         case (st_q)
            StMuted, StUnmuted, StRampUp, StRampDown: begin
               if (mute && st_q != StMuted) begin
                  g_d  = g_dn;
                  st_d = (g_dn == 9'd0) ? StMuted : StRampDown;
               end else if (!mute && st_q != StUnmuted) begin
                  g_d  = g_up[8:0];
                  st_d = (g_up == G_FULL) ? StUnmuted : StRampUp;
               end
            end
            default: begin
               st_d = StMuted;
               g_d  = 9'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         r_q     <= '0;
         sat_q   <= '0;
         clip2_q <= 1'b0;
         dac_q   <= {1'b1, {(DAC_WIDTH - 1){1'b0}}};
         clip_q  <= 1'b0;
      end else if (ena) begin
         r_q     <= r_d;
         sat_q   <= sat_d;
         clip2_q <= clip2_d;
         dac_q   <= dac_d;
         clip_q  <= clip2_q;
      end
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         fill_q  <= 2'd0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         g_q     <= 9'd0;
         st_q    <= StMuted;
      end else begin
         fill_q  <= fill_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         g_q     <= g_d;
         st_q    <= st_d;
      end
   end

   assign dac_in     = dac_q;
   assign dac_valid  = valid_q;
   assign clip       = clip_q;
   assign clip_count = cnt_q;
   assign muted      = (st_q == StMuted);

endmodule
